// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: byte-lane masking, store shifting, load extension, error response.
// Latency: aligned access resp_valid 3 cycles after accept (gnt/rvalid next cycle); split adds 2.
// Backpressure: req_ready only in IDLE; mem_req and its address/be/wdata held until mem_gnt.
//
// Ports: clk/rst_n (async active-low); req_* core request (valid/ready); resp_* one-cycle response;
//        mem_* handshaked data-memory port (req/gnt for the command, rvalid/rdata/err for the reply).
// Optional feature: LSU_MISALIGN_SPLIT_EN. When defined, line-crossing accesses are split into two
//        aligned bus transactions. When undefined, any access not aligned to its size is answered
//        with resp_err and never reaches the bus.
`timescale 1ns/1ps
module lsu_mc #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err
);
    localparam int OFF_W = $clog2(BE_W);
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int SPAN = 2;   // lanes/data tracked across two adjacent bus words
`else
    localparam int SPAN = 1;   // aligned accesses never leave the first bus word
`endif

    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

    state_t                     state_q, state_d;
    logic                       store_q;
    logic [2:0]                 func3_q;
    logic [ADDR_W-1:0]          addr_q;
    logic [DATA_W-1:0]          wdata_q;
    logic                       err_q;
    logic [SPAN*DATA_W-1:0]     rbuf_q;

    logic                       illegal;
    logic                       req_bad;
    logic [OFF_W-1:0]           off;
    logic [OFF_W+2:0]           shamt;
    int                         nbytes;
    logic [SPAN*BE_W-1:0]       lane_mask;
    logic [SPAN*BE_W-1:0]       be_full;
    logic [SPAN*DATA_W-1:0]     wdata_full;
    logic [DATA_W-1:0]          sh;
    logic                       signbit;
    logic [DATA_W-1:0]          ext;
    logic [ADDR_W-1:0]          base_addr;

    // Request legality, evaluated on the live request while in IDLE.
    always_comb begin
        illegal = (req_func3 == 3'b111)
               || (req_store && req_func3[2])
               || ((DATA_W == 32) && (req_func3 == 3'b011 || req_func3 == 3'b110));
        req_bad = illegal;
`ifndef LSU_MISALIGN_SPLIT_EN
        case (req_func3[1:0])
            2'd0:    req_bad = illegal;
            2'd1:    req_bad = illegal || req_addr[0];
            2'd2:    req_bad = illegal || (|req_addr[1:0]);
            default: req_bad = illegal || (|req_addr[2:0]);
        endcase
`endif
    end

    // Lane/shift arithmetic on the latched request.
    always_comb begin
        off        = addr_q[OFF_W-1:0];
        shamt      = {off, 3'b000};
        nbytes     = 32'd1 << func3_q[1:0];
        lane_mask  = '0;
        for (int i = 0; i < SPAN*BE_W; i++) begin
            if (i < nbytes) lane_mask[i] = 1'b1;
        end
        be_full    = lane_mask << off;
        wdata_full = (SPAN*DATA_W)'(wdata_q) << shamt;
        base_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    // Load extraction: bring the addressed byte to bit 0, then extend from the access size.
    always_comb begin
        sh = DATA_W'(rbuf_q >> shamt);
        case (func3_q[1:0])
            2'd0:    signbit = sh[7];
            2'd1:    signbit = sh[15];
            2'd2:    signbit = sh[31];
            default: signbit = sh[DATA_W-1];
        endcase
        ext = '0;
        for (int i = 0; i < DATA_W; i++) begin
            ext[i] = (i < 8*nbytes) ? sh[i] : (signbit & ~func3_q[2]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (req_valid) state_d = req_bad ? RESP : REQ0;
            REQ0:  if (mem_gnt) state_d = WAIT0;
            WAIT0: if (mem_rvalid) begin
                state_d = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
                if (!mem_err && (|be_full[SPAN*BE_W-1:BE_W])) state_d = REQ1;
`endif
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            REQ1:  if (mem_gnt) state_d = WAIT1;
            WAIT1: if (mem_rvalid) state_d = RESP;
`endif
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            func3_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_valid) begin
                store_q <= req_store;
                func3_q <= req_func3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_bad;
                rbuf_q  <= '0;
            end
            if (state_q == WAIT0 && mem_rvalid) begin
                rbuf_q[DATA_W-1:0] <= mem_rdata;
                err_q              <= mem_err;
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            if (state_q == WAIT1 && mem_rvalid) begin
                rbuf_q[SPAN*DATA_W-1:DATA_W] <= mem_rdata;
                err_q                        <= mem_err;
            end
`endif
        end
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_err   = resp_valid && err_q;
        resp_rdata = (resp_valid && !err_q && !store_q) ? ext : '0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        mem_be     = '0;
        mem_wdata  = '0;
        if (state_q == REQ0) begin
            mem_req   = 1'b1;
            mem_addr  = base_addr;
            mem_be    = be_full[BE_W-1:0];
            mem_wdata = wdata_full[DATA_W-1:0];
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        if (state_q == REQ1) begin
            mem_req   = 1'b1;
            mem_addr  = base_addr + ADDR_W'(BE_W);
            mem_be    = be_full[SPAN*BE_W-1:BE_W];
            mem_wdata = wdata_full[SPAN*DATA_W-1:DATA_W];
        end
`endif
        mem_we = mem_req && store_q;
    end
endmodule
